// File: rtl/grf_wport_arb.sv
// grf_wport_arb: shares the GRF write port between the W stage (A) and a buffered mult/div result (B)
//   in : clk, reset_n (async, active-low), we_a/wa_a/wd_a (A write), b_valid/wa_b/wd_b (B offer)
//   out: b_ready, sel (1 = A owns the port), grf_we/grf_wa/grf_wd (GRF port),
//        stall_a (forced B grant, A must re-present), pend/pend_wa (buffered B entry)
module grf_wport_arb #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we_a,
    input  logic [4:0]  wa_a,
    input  logic [31:0] wd_a,
    input  logic        b_valid,
    input  logic [4:0]  wa_b,
    input  logic [31:0] wd_b,
    output logic        b_ready,
    output logic        sel,
    output logic        grf_we,
    output logic [4:0]  grf_wa,
    output logic [31:0] grf_wd,
    output logic        stall_a,
    output logic        pend,
    output logic [4:0]  pend_wa
);
    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] pend_wd;
    logic        grant_b, load;
    assign grant_b = (state == FORCE) || (state == WAIT && !we_a);
    assign b_ready = (state == IDLE) || grant_b;
    // writes to r0 complete the handshake but are never buffered
    assign load    = b_valid && b_ready && (wa_b != 5'd0);
    assign sel     = !grant_b;
    assign grf_we  = grant_b ? 1'b1 : (we_a && wa_a != 5'd0);
    assign grf_wa  = grant_b ? pend_wa : wa_a;
    assign grf_wd  = grant_b ? pend_wd : wd_a;
    assign stall_a = (state == FORCE);
    assign pend    = (state != IDLE);
    // b_ready low means WAIT with A writing: either A supersedes the entry or it keeps waiting
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (b_ready) begin
            state_nx = load ? WAIT : IDLE;
            cnt_nx   = 4'd0;
        end else if (wa_a == pend_wa) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
        end else if (cnt == 4'(MAX_WAIT - 1)) begin
            state_nx = FORCE;
        end else begin
            cnt_nx = cnt + 4'd1;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend_wa <= 5'd0;
            pend_wd <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (load) begin
                pend_wa <= wa_b;
                pend_wd <= wd_b;
            end
        end
    end
endmodule
